// File: rtl/gcd_multimode_engine_if.sv
// gcd_multimode_engine_if: operand/result valid-ready bundle for the GCD engine
interface gcd_multimode_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [CNT_W-1:0] cycles;
    logic             err;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, out, cycles, err
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, out, cycles, err
    );
endinterface

// File: rtl/gcd_multimode_engine.sv
// gcd_multimode_engine: subtractive Euclid / binary Stein GCD with valid-ready handshakes
module gcd_multimode_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    gcd_multimode_engine_if.slave bus
);
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SUB, BIN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_err;
    logic             w_accept;
    logic             w_zero;
    logic             w_eq;
    logic             w_a_even;
    logic             w_b_even;
    logic             w_gt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_zero    = (bus.x == '0) || (bus.y == '0);
    assign w_eq      = (r_a == r_b);
    assign w_a_even  = ~r_a[0];
    assign w_b_even  = ~r_b[0];
    assign w_gt      = (r_a > r_b);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out       = r_out;
    assign bus.cycles    = r_cnt;
    assign bus.err       = r_err;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state: zero operands skip compute, mode picks the algorithm
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = w_zero ? DONE : (bus.mode ? BIN : SUB);
            SUB,
            BIN:     if (w_eq) w_next = DONE;
            default: if (bus.out_ready) w_next = IDLE;
        endcase
    end

    // Datapath: operand load at accept, one reduction step per compute cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= '0;
            r_cnt <= '0;
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.x;
            r_b   <= bus.y;
            r_k   <= '0;
            r_cnt <= '0;
            r_err <= (bus.x == '0) && (bus.y == '0);
            if (w_zero) r_out <= bus.x | bus.y;
        end else if (r_state == SUB) begin
            r_cnt <= w_cnt_inc;
            if (w_eq)      r_out <= r_a;
            else if (w_gt) r_a   <= r_a - r_b;
            else           r_b   <= r_b - r_a;
        end else if (r_state == BIN) begin
            r_cnt <= w_cnt_inc;
            if (w_eq) r_out <= r_a << r_k;
            else if (w_a_even && w_b_even) begin
                r_a <= r_a >> 1;
                r_b <= r_b >> 1;
                r_k <= r_k + 1'b1;
            end
            else if (w_a_even) r_a <= r_a >> 1;
            else if (w_b_even) r_b <= r_b >> 1;
            else if (w_gt)     r_a <= (r_a - r_b) >> 1;
            else               r_b <= (r_b - r_a) >> 1;
        end
    end
endmodule

// File: tb/tb_gcd_multimode_engine.sv
// tb_gcd_multimode_engine: vector table, hand sequences and random pairs against a reference model
module tb_gcd_multimode_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gcd_multimode_engine_if #(.WIDTH(8), .CNT_W(16)) bus ();
    gcd_multimode_engine_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

    gcd_multimode_engine #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    gcd_multimode_engine #(.WIDTH(8), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.x         = bus.x;
    assign bus4.y         = bus.y;
    assign bus4.mode      = bus.mode;
    assign bus4.out_ready = bus.out_ready;

    typedef struct {
        int x;
        int y;
        int mode;
        int out;
        int cyc;
        int err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive Euclid steps equal the sum of the division quotients (last one ends on equality)
    function automatic int sub_cyc(input int a, input int b);
        int s = 0;
        int t;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    function automatic int bin_cyc(input int a, input int b);
        int c = 1;
        while (a != b) begin
            c++;
            if (a % 2 == 0 && b % 2 == 0) begin a /= 2; b /= 2; end
            else if (a % 2 == 0) a /= 2;
            else if (b % 2 == 0) b /= 2;
            else if (a > b) a = (a - b) / 2;
            else b = (b - a) / 2;
        end
        return c;
    endfunction

    task automatic start(input int x, input int y, input int m);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.x = x[7:0];
        bus.y = y[7:0];
        bus.mode = m[0];
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x = 8'hA5;
        bus.y = 8'h5A;
        bus.mode = ~m[0];
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic finish(input string name, input int eo, input int ec, input int ee);
        int n;
        wait_valid(n);
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_latency"}, n, ec);
        check({name, "_out"}, bus.out, eo);
        check({name, "_cycles"}, bus.cycles, ec);
        check({name, "_err"}, bus.err, ee);
        check({name, "_sat_cycles"}, bus4.cycles, ec > 15 ? 15 : ec);
        check({name, "_sat_out"}, bus4.out, eo);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_valid_fall"}, bus.out_valid, 0);
        check({name, "_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        int lat;
        int hold_out, hold_cyc, hold_err;
        vecs[0] = '{12,  8, 0,  4,   3, 0};
        vecs[1] = '{12,  8, 1,  4,   5, 0};
        vecs[2] = '{255, 1, 0,  1, 255, 0};
        vecs[3] = '{255, 1, 1,  1,   8, 0};
        vecs[4] = '{0,   9, 0,  9,   0, 0};
        vecs[5] = '{0,   0, 1,  0,   0, 1};
        vecs[6] = '{9,   6, 1,  3,   3, 0};
        vecs[7] = '{7,   7, 0,  7,   1, 0};
        vecs[8] = '{64, 48, 1, 16,   8, 0};
        vecs[9] = '{5,   0, 0,  5,   0, 0};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out", bus.out, 0);
        check("reset_cycles", bus.cycles, 0);
        check("reset_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            start(vecs[i].x, vecs[i].y, vecs[i].mode);
            finish($sformatf("vec%0d", i), vecs[i].out, vecs[i].cyc, vecs[i].err);
        end
        start(12, 8, 0);
        wait_valid(lat);
        check("bp_latency", lat, 3);
        hold_out = bus.out;
        hold_cyc = bus.cycles;
        hold_err = bus.err;
        check("bp_out_first", hold_out, 4);
        bus.x = 8'd9;
        bus.y = 8'd6;
        bus.mode = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_hold", bus.out, hold_out);
            check("bp_cycles_hold", bus.cycles, hold_cyc);
            check("bp_err_hold", bus.err, hold_err);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_accepted", bus.in_ready, 0);
        finish("bp_next", 3, 3, 0);
        start(200, 3, 0);
        repeat (20) @(posedge clk);
        #2;
        check("mid_sub_busy", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out", bus.out, 0);
        check("abort_cycles", bus.cycles, 0);
        check("abort_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", bus.in_ready, 1);
        start(9, 6, 1);
        finish("after_abort", 3, 3, 0);
        for (int i = 0; i < 40; i++) begin
            int rx, ry, rm, eo, ec, ee;
            rx = (i % 10 == 3) ? 0 : int'($urandom_range(0, 255));
            ry = (i % 13 == 5) ? 0 : int'($urandom_range(0, 255));
            rm = int'($urandom_range(0, 1));
            if (rx == 0 || ry == 0) begin
                eo = rx | ry;
                ec = 0;
                ee = (rx == 0 && ry == 0) ? 1 : 0;
            end else begin
                eo = gcd_ref(rx, ry);
                ec = rm ? bin_cyc(rx, ry) : sub_cyc(rx, ry);
                ee = 0;
            end
            start(rx, ry, rm);
            finish($sformatf("rand%0d_%0d_%0d_m%0d", i, rx, ry, rm), eo, ec, ee);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gcd_multimode_engine.md
Name: gcd_multimode_engine

Overview:
- Parametrised next-generation GCD unit: computes gcd(x, y) on WIDTH-bit unsigned operands.
- Per-transaction mode select: subtractive Euclid or binary (Stein) algorithm.
- Valid/ready handshakes on input and output replace the single-shot go/done.
- Reports the number of compute cycles used and flags the degenerate case gcd(0,0).
- Sits beside the existing GCD calculator as the reusable arithmetic core for wider datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2 or greater.
- CNT_W, 16, width of the cycle-count output; the count saturates at all-ones.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low; all state clears while rst=0
- in_valid  in  1  operand pair presented
- in_ready  out  1  engine can accept; high only in IDLE
- x  in  WIDTH  operand A, unsigned
- y  in  WIDTH  operand B, unsigned
- mode  in  1  0=subtractive Euclid, 1=binary Stein; sampled at accept
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes result
- out  out  WIDTH  gcd result
- cycles  out  CNT_W  compute cycles used by this transaction
- err  out  1  high when x=0 and y=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, out=0, cycles=0, err=0, out_valid=0. in_ready=1 once in IDLE.
- States: IDLE, SUB, BIN, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept occurs on a clock edge with in_valid=1 and in_ready=1. At accept, register a=x, b=y, mode_r=mode, k=0, cnt=0.
- Zero operand at accept: go directly to DONE.
  - out=x|y.
  - err=(x==0 && y==0).
  - cycles=0.
  - out_valid rises the cycle after accept.
- Otherwise: mode_r=0 goes to SUB; mode_r=1 goes to BIN. Set err=0.
- SUB, one action per cycle; cnt increments each cycle:
  - If a==b: out=a, go to DONE.
  - Else if a<b: b=b-a.
  - Else: a=a-b.
- BIN, one action per cycle, first match wins; cnt increments each cycle:
  - If a==b: out=a<<k, go to DONE.
  - Else if a and b both even: a>>=1, b>>=1, k++.
  - Else if a even: a>>=1.
  - Else if b even: b>>=1.
  - Else if a>b: a=(a-b)>>1.
  - Else: b=(b-a)>>1.
  - k is clog2(WIDTH)+1 bits wide. The a<<k result always fits in WIDTH bits; truncate to WIDTH.
- cycles reports cnt including the final equality cycle. cnt saturates at 2^CNT_W-1.
- Latency: for an accept at edge T with C compute cycles, out_valid is high from cycle T+C+1.
- DONE:
  - out, cycles and err are held stable while out_ready=0.
  - An edge with out_ready=1 returns the engine to IDLE. out_valid falls the next cycle.
  - There is no same-cycle re-accept: in_ready=0 in DONE.
- in_valid is ignored outside IDLE. x, y and mode may change freely after accept.
- Reset asserted mid-computation or in DONE aborts the transaction with no output and returns to the reset values.
- All arithmetic is unsigned. Subtraction is only ever performed with the larger operand as minuend, so no underflow occurs.

Test Plan:
- WIDTH=8, mode=0, x=12, y=8 -> out=4, cycles=3, err=0; out_valid 4 cycles after accept.
- WIDTH=8, mode=1, x=12, y=8 -> sequence (6,4,k1), (3,2,k2), (3,1), (1,1), equal; out=4, cycles=5.
- WIDTH=8, x=255, y=1: mode=0 -> out=1, cycles=255; mode=1 -> out=1, cycles=8.
- Zero operands:
  - x=0, y=9 -> out=9, err=0, cycles=0, out_valid the cycle after accept.
  - x=0, y=0 -> out=0, err=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out, cycles and err stay stable; in_ready=0; no new accept.
  - Then out_ready=1 -> IDLE, and the next pair is accepted.
- Drive rst=0 asynchronously mid-SUB with x=200, y=3 -> out_valid=0, out=0 and cycles=0 immediately. After release, in_ready=1, and a fresh x=9, y=6, mode=1 transaction yields out=3.
